seq_magnitude_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator. Successor to the team's combinational 8-bit cascadable comparator.
- Compares two WIDTH-bit operands CHUNK bits per clock, starting at the MSB chunk, and exits as soon as a chunk differs.
- Supports an unsigned/signed mode and the same lin/ein/gin cascade convention.
- Uses a start/done handshake so wide datapaths can share one compact compare engine.

---
 rtl/seq_magnitude_comparator.sv | 111 +++++++++++
 tb/tb_seq_magnitude_comparator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator that walks CHUNK bits per clock from the MSB and stops at the first differing chunk.
// Latency is 1..WIDTH/CHUNK cycles after start. start is ignored while busy, and done pulses once per accepted request.
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             lin,
    input  logic             ein,
    input  logic             gin,
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             equal,
    output logic             greater
);

    localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    K_LAST   = KW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("seq_magnitude_comparator: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             lin_q;
    logic             ein_q;
    logic             gin_q;
    logic [KW-1:0]    k;

    // Operands are shifted left after every equal chunk, so the live chunk always sits at the top.
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    assign chunk_a = a_q[WIDTH-1 -: CHUNK];
    assign chunk_b = b_q[WIDTH-1 -: CHUNK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            lin_q   <= 1'b0;
            ein_q   <= 1'b0;
            gin_q   <= 1'b0;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            less    <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Flipping the sign bits turns two's-complement order into unsigned order.
                        a_q     <= signed_mode ? (a ^ MSB_MASK) : a;
                        b_q     <= signed_mode ? (b ^ MSB_MASK) : b;
                        lin_q   <= lin;
                        ein_q   <= ein;
                        gin_q   <= gin;
                        k       <= '0;
                        less    <= 1'b0;
                        equal   <= 1'b0;
                        greater <= 1'b0;
                        busy    <= 1'b1;
                        state   <= COMPARE;
                    end else begin
                        state <= IDLE;
                    end
                end
                COMPARE: begin
                    if (chunk_a != chunk_b) begin
                        less    <= (chunk_a < chunk_b);
                        greater <= (chunk_a > chunk_b);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (k == K_LAST) begin
                        // Cascade priority ein > gin > lin; nothing asserted reads as equal.
                        equal   <= ein_q || (!gin_q && !lin_q);
                        greater <= !ein_q && gin_q;
                        less    <= !ein_q && !gin_q && lin_q;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        k   <= k + 1'b1;
                        a_q <= a_q << CHUNK;
                        b_q <= b_q << CHUNK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: a 32/4 instance and an 8/8 instance, checked against a scoreboard of expected results.
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [31:0] a, b;
    logic        signed_mode, lin, ein, gin;
    logic        busy0, done0, less0, equal0, greater0;
    logic        busy1, done1, less1, equal1, greater1;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
        .signed_mode(signed_mode), .lin(lin), .ein(ein), .gin(gin),
        .busy(busy0), .done(done0), .less(less0), .equal(equal0), .greater(greater0)
    );

    seq_magnitude_comparator #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a[7:0]), .b(b[7:0]),
        .signed_mode(signed_mode), .lin(lin), .ein(ein), .gin(gin),
        .busy(busy1), .done(done1), .less(less1), .equal(equal1), .greater(greater1)
    );

    localparam logic [2:0] R_L = 3'b100;
    localparam logic [2:0] R_E = 3'b010;
    localparam logic [2:0] R_G = 3'b001;

    typedef struct packed {
        logic [2:0] res;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {busy, done, less, equal, greater}
    function automatic logic [4:0] st(input int sel);
        return (sel == 0) ? {busy0, done0, less0, equal0, greater0}
                          : {busy1, done1, less1, equal1, greater1};
    endfunction

    task automatic drive(input int sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic sm, input logic l, input logic e, input logic g,
                         input logic [2:0] res, input int lat);
        exp_t x;
        @(negedge clk);
        a = av; b = bv; signed_mode = sm; lin = l; ein = e; gin = g;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        x.res = res;
        x.lat = lat;
        sb.push_back(x);
    endtask

    // Counts edges from the caller's reference edge (already edges have elapsed) until done.
    task automatic wait_done(input int sel, input int already, input string tag);
        exp_t       x;
        logic [4:0] s;
        int         lat;
        lat = 0;
        x   = sb.pop_front();
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            s = st(sel);
            if (s[3]) begin
                lat = already + i;
                break;
            end
        end
        chk({tag, " latency"}, lat, x.lat);
        chk({tag, " result"}, {29'd0, s[2:0]}, {29'd0, x.res});
    endtask

    task automatic run_cmp(input int sel, input logic [31:0] av, input logic [31:0] bv,
                           input logic sm, input logic l, input logic e, input logic g,
                           input logic [2:0] res, input int lat, input string tag);
        logic [4:0] s;
        drive(sel, av, bv, sm, l, e, g, res, lat);
        @(posedge clk);
        #1;
        s = st(sel);
        chk({tag, " busy"}, {31'd0, s[4]}, 32'd1);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_done(sel, 0, tag);
        @(posedge clk);
        #1;
        chk({tag, " held"}, {27'd0, st(sel)}, {29'd0, res});
    endtask

    initial begin
        logic [4:0] s;
        int         seen;
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0; lin = 1'b0; ein = 1'b0; gin = 1'b0;
        #2;
        chk("reset state w32", {27'd0, st(0)}, 32'd0);
        chk("reset state w8", {27'd0, st(1)}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmp(0, 32'h8000_000B, 32'h0000_0007, 1'b0, 1'b0, 1'b1, 1'b0, R_G, 1, "msb unsigned");
        run_cmp(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, R_L, 1, "signed msb");
        run_cmp(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, R_G, 1, "unsigned msb");
        run_cmp(0, 32'h0000_00AB, 32'h0000_00AA, 1'b0, 1'b0, 1'b0, 1'b0, R_G, 8, "lsb greater");
        run_cmp(0, 32'h0000_00AA, 32'h0000_00AB, 1'b0, 1'b0, 1'b0, 1'b0, R_L, 8, "lsb less");
        run_cmp(0, 32'h0012_0000, 32'h0034_0000, 1'b0, 1'b0, 1'b0, 1'b0, R_L, 3, "mid chunk");
        run_cmp(0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, R_L, 8, "cascade lin");
        run_cmp(0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b1, R_E, 8, "cascade ein");
        run_cmp(0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1, R_G, 8, "cascade gin");
        run_cmp(0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, R_E, 8, "cascade none");
        run_cmp(0, 32'hFFFF_FFF0, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b0, 1'b0, R_L, 8, "signed neg");

        // start pulsed at E3 while busy, with different operands: must be ignored
        drive(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, R_L, 8);
        @(posedge clk);
        #1;
        start0 = 1'b0;
        a = 32'hFFFF_FFFF; b = 32'h0; signed_mode = 1'b1; ein = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_done(0, 3, "start while busy");

        // start held through DONE: back-to-back accept
        drive(0, 32'h1000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, R_G, 1);
        @(posedge clk);
        #1;
        a = 32'h0000_0000; b = 32'h0000_0005; ein = 1'b1;
        sb.push_back('{res: R_L, lat: 8});
        wait_done(0, 0, "b2b first");
        @(posedge clk);
        #1;
        chk("b2b cleared", {27'd0, st(0)}, {27'd0, 5'b10000});
        start0 = 1'b0;
        wait_done(0, 0, "b2b second");

        // asynchronous reset between E3 and E4
        drive(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, R_L, 8);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        start0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #3;
        s = st(0);
        chk("busy before reset", {31'd0, s[4]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset clears", {27'd0, st(0)}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            s = st(0);
            if (s[3]) seen++;
        end
        chk("no done after reset", seen, 32'd0);
        run_cmp(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, R_E, 8, "post reset");

        run_cmp(1, 32'h0000_000A, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, R_G, 1, "w8 greater");
        run_cmp(1, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, R_L, 1, "w8 signed");
        run_cmp(1, 32'h0000_005A, 32'h0000_005A, 1'b0, 1'b0, 1'b0, 1'b1, R_G, 1, "w8 cascade");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
